// File: rtl/sum_frame_accumulator.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | sum_frame_accumulator: sums FRAME_N 9-bit adder results, drains LSB first   |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module sum_frame_accumulator #(
  parameter int ACC_W   = 16,
  parameter int FRAME_N = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clear,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] sum_in,
  input  logic       cout_in,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_byte,
  output logic       out_last,
  output logic       overflow
);

  localparam int NBYTES = ACC_W / 8;
  localparam int IDX_W  = $clog2(NBYTES);
  localparam int CNT_W  = (FRAME_N > 1) ? $clog2(FRAME_N) : 1;

  typedef enum logic [0:0] {
    ST_ACCUM = 1'b0,
    ST_DRAIN = 1'b1
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [ACC_W-1:0]   r_acc;
  logic [CNT_W-1:0]   r_cnt;
  logic [IDX_W-1:0]   r_idx;
  logic               r_overflow;

  logic               w_accept;
  logic               w_xfer;
  logic               w_frame_done;
  logic               w_last_byte;
  logic [ACC_W:0]     w_sum;

  assign w_accept     = in_valid && (r_state == ST_ACCUM);
  assign w_xfer       = out_ready && (r_state == ST_DRAIN);
  assign w_frame_done = w_accept && (r_cnt == CNT_W'(FRAME_N - 1));
  assign w_last_byte  = (r_idx == IDX_W'(NBYTES - 1));
  // Extra top bit captures the carry out of the accumulator for overflow.
  assign w_sum        = {1'b0, r_acc} + (ACC_W + 1)'({cout_in, sum_in});

  always_comb begin
    w_state_nxt = r_state;
    if (clear) begin
      w_state_nxt = ST_ACCUM;
    end else begin
      case (r_state)
        ST_ACCUM: if (w_frame_done) w_state_nxt = ST_DRAIN;
        ST_DRAIN: if (w_xfer && w_last_byte) w_state_nxt = ST_ACCUM;
        default:  w_state_nxt = ST_ACCUM;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_ACCUM;
    else        r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc      <= '0;
      r_cnt      <= '0;
      r_idx      <= '0;
      r_overflow <= 1'b0;
    end else if (clear) begin
      r_acc      <= '0;
      r_cnt      <= '0;
      r_idx      <= '0;
      r_overflow <= 1'b0;
    end else if (w_accept) begin
      r_acc <= w_sum[ACC_W-1:0];
      if (w_sum[ACC_W]) r_overflow <= 1'b1;
      r_cnt <= w_frame_done ? '0 : r_cnt + 1'b1;
      r_idx <= '0;
    end else if (w_xfer) begin
      if (w_last_byte) begin
        r_acc      <= '0;
        r_overflow <= 1'b0;
        r_idx      <= '0;
      end else begin
        r_idx <= r_idx + 1'b1;
      end
    end
  end

  assign in_ready  = (r_state == ST_ACCUM);
  assign out_valid = (r_state == ST_DRAIN);
  assign out_byte  = (r_state == ST_DRAIN) ? r_acc[{r_idx, 3'b000} +: 8] : 8'h00;
  assign out_last  = (r_state == ST_DRAIN) && w_last_byte;
  assign overflow  = r_overflow;

endmodule
`default_nettype wire
